// File: rtl/digit_edit_ctrl.sv
// Digit edit controller. It sits after the key debouncer.
// k0 moves the cursor, and on the last digit it commits the working copy.
// k1 increments the digit under the cursor. A held k1 level auto-repeats
// the increment. An idle EDIT state reverts the working copy on timeout.
module digit_edit_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_MAX      = 9,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  parameter int BLINK_CYCLES   = 25_000_000,
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    k0,
  input  logic                    k1,
  input  logic                    k1_lvl,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [4*NUM_DIGITS-1:0] work,
  output logic [SEL_W-1:0]        sel,
  output logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    editing,
  output logic                    commit,
  output logic                    abort
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BLK_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, EDIT} state_t;

  state_t              state;
  logic                pend_k0;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [REP_W-1:0]    rep_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_off;
  logic [4*NUM_DIGITS-1:0] work_inc;

  // Auto-repeat: first shot when the hold reaches HOLD_CYCLES, then every REPEAT_CYCLES
  logic held_long, auto_inc, inc_ev, sel_ev;
  assign held_long = (hold_cnt == HOLD_SAT);
  assign auto_inc  = k1_lvl && (held_long ? (rep_cnt == REP_LAST) : (hold_cnt == HOLD_LAST));
  assign inc_ev    = k1 || auto_inc;
  assign sel_ev    = k0 || pend_k0;

  // Working copy with the cursor digit bumped, wrapping DIGIT_MAX -> 0
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [3:0] d;
    assign d = work[4*i +: 4];
    assign work_inc[4*i +: 4] = (sel != SEL_W'(i)) ? d :
                                (d == 4'(DIGIT_MAX)) ? 4'd0 : d + 4'd1;
  end

  assign blink_mask = (editing && blink_off) ? (NUM_DIGITS'(1) << sel) : '0;

  // Hold/repeat counters run only while editing with k1 held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (state != EDIT || !k1_lvl) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else if (!held_long) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
      rep_cnt  <= '0;
    end else begin
      rep_cnt  <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + REP_W'(1);
    end
  end

  // Blink phase: starts "on" at EDIT entry, toggles every BLINK_CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (state != EDIT) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + BLK_W'(1);
    end
  end

  // Main edit FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      value   <= '0;
      work    <= '0;
      sel     <= '0;
      editing <= 1'b0;
      commit  <= 1'b0;
      abort   <= 1'b0;
      pend_k0 <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      commit <= 1'b0;
      abort  <= 1'b0;
      case (state)
        IDLE: begin
          work    <= value;
          pend_k0 <= 1'b0;
          tmo_cnt <= '0;
          sel     <= '0;
          if (k0) begin
            state   <= EDIT;
            editing <= 1'b1;
          end
        end
        EDIT: begin
          if (inc_ev) work <= work_inc;
          // An increment takes the cycle, so a coincident select waits one cycle
          if (inc_ev && sel_ev) begin
            pend_k0 <= 1'b1;
          end else if (sel_ev) begin
            pend_k0 <= 1'b0;
            if (sel == SEL_LAST) begin
              value   <= work;
              commit  <= 1'b1;
              sel     <= '0;
              state   <= IDLE;
              editing <= 1'b0;
            end else begin
              sel <= sel + SEL_W'(1);
            end
          end
          // Any key activity keeps the edit alive. A quiet stretch reverts it.
          if (inc_ev || sel_ev) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
            work    <= value;
            abort   <= 1'b1;
            sel     <= '0;
            state   <= IDLE;
            editing <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
